// File: rtl/uart_byte_fifo_if.sv
// Byte FIFO bus: write strobe from the receiver, rdy/new_data handshake to the transmitter,
// plus fill-level status. The FIFO takes the slave side; the driver of wr_en/rd_rdy takes the master side.
interface uart_byte_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_rdy;
  logic                     rd_valid;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output wr_en, wr_data, rd_rdy,
    input  rd_valid, rd_data, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_rdy,
    output rd_valid, rd_data, full, empty, count, overflow
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between uart_rx and uart_tx; write visible after one edge, 2-cycle pass-through.
// Writes into a full FIFO are dropped (sticky overflow); one pop per rdy fall-then-rise of the sink.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_byte_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_RDY  = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;

  logic full, empty, wr_accept;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  // full is taken before any same-cycle pop, so a write into a full FIFO always drops
  assign wr_accept = bus.wr_en && !full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else if (bus.wr_en) begin
      overflow_d = 1'b1;
    end
  end

  // Read side: one strobe, then wait for the sink to go busy and come back ready
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && bus.rd_rdy) begin
          rd_data_d  = mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d   = rd_ptr_q + PW'(1);
          rd_valid_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.rd_rdy) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (bus.rd_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_uart_byte_fifo.sv
// Directed bench for uart_byte_fifo with a uart_tx-like sink and an in-order scoreboard.
module tb_uart_byte_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_byte_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  uart_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         n_valid  = 0;
  int         sink_cnt = 0;
  int         busy_len = 1;
  bit         sink_en  = 1'b1;
  bit         prev_vld = 1'b0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, score any presented byte, then update the sink's rdy
  task automatic step();
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    if (bus.rd_valid) begin
      chk("rd_valid_width", 32'(prev_vld), 0);
      chk("pop_expected", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        chk("rd_data", bus.rd_data, exp_b);
      end
      n_valid++;
      sink_cnt = busy_len;
    end else if (sink_cnt > 0) begin
      sink_cnt--;
    end
    prev_vld   = bus.rd_valid;
    bus.rd_rdy = sink_en && (sink_cnt == 0);
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (q.size() < DEPTH) q.push_back(b);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_done", q.size(), 0);
    repeat (busy_len + 4) step();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.wr_en = 1'b0;
    step();
    step();
    q.delete();
    sink_cnt   = 0;
    sink_en    = 1'b1;
    prev_vld   = 1'b0;
    bus.rd_rdy = 1'b1;
    rst_n      = 1'b1;
  endtask

  initial begin
    int v0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_rdy  = 1'b0;

    // Reset with random inputs
    rst_n = 1'b0;
    repeat (2) begin
      bus.wr_en   = 1'($urandom);
      bus.wr_data = 8'($urandom);
      bus.rd_rdy  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bus.wr_en  = 1'b0;
    bus.rd_rdy = 1'b1;
    rst_n      = 1'b1;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);

    // Single byte, slow sink
    busy_len = 20;
    wr(8'h41);
    chk("single_vld_n", 32'(bus.rd_valid), 0);
    chk("single_count_n", 32'(bus.count), 1);
    chk("single_empty_n", 32'(bus.empty), 0);
    step();
    chk("single_vld_n1", 32'(bus.rd_valid), 1);
    chk("single_data_n1", 32'(bus.rd_data), 8'h41);
    chk("single_count_n1", 32'(bus.count), 0);
    step();
    chk("single_vld_n2", 32'(bus.rd_valid), 0);
    chk("single_data_hold", 32'(bus.rd_data), 8'h41);
    v0 = n_valid;
    repeat (25) step();
    chk("single_no_second", n_valid - v0, 0);
    chk("single_empty_end", 32'(bus.empty), 1);

    // Fill, overflow, then drain through a slow sink
    sink_en    = 1'b0;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(8'(i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), DEPTH);
    chk("fill_overflow0", 32'(bus.overflow), 0);
    wr(8'h99);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), DEPTH);
    busy_len = 10;
    sink_en  = 1'b1;
    v0 = n_valid;
    drain(600);
    chk("fill_recv_n", n_valid - v0, DEPTH);
    chk("fill_ovf_sticky", 32'(bus.overflow), 1);
    chk("fill_empty_end", 32'(bus.empty), 1);

    // Write in the same cycle as a pop with count=5
    busy_len   = 3;
    sink_en    = 1'b0;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
    chk("conc_count_pre", 32'(bus.count), 5);
    sink_en    = 1'b1;
    bus.rd_rdy = 1'b1;
    wr(8'hA5);
    chk("conc_pop", 32'(bus.rd_valid), 1);
    chk("conc_count", 32'(bus.count), 5);
    drain(200);

    // Wrap-around stream
    do_reset();
    busy_len = 1;
    v0 = n_valid;
    for (int i = 0; i < 40; i++) begin
      wr(8'h10 + 8'(i));
      step();
      step();
    end
    drain(400);
    chk("wrap_recv_n", n_valid - v0, 40);
    chk("wrap_overflow", 32'(bus.overflow), 0);
    chk("wrap_empty", 32'(bus.empty), 1);

    // Reset while waiting on a busy sink
    sink_en    = 1'b0;
    bus.rd_rdy = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    busy_len   = 10;
    sink_en    = 1'b1;
    bus.rd_rdy = 1'b1;
    step();
    chk("mid_pop", 32'(bus.rd_valid), 1);
    rst_n = 1'b0;
    step();
    chk("mid_empty", 32'(bus.empty), 1);
    chk("mid_rd_valid", 32'(bus.rd_valid), 0);
    chk("mid_count", 32'(bus.count), 0);
    chk("mid_rd_data", 32'(bus.rd_data), 0);
    q.delete();
    sink_cnt   = 0;
    prev_vld   = 1'b0;
    bus.rd_rdy = 1'b1;
    rst_n      = 1'b1;
    step();
    chk("mid_no_pop", 32'(bus.rd_valid), 0);
    wr(8'h5A);
    chk("mid_wr_vld", 32'(bus.rd_valid), 0);
    step();
    chk("mid_first_vld", 32'(bus.rd_valid), 1);
    chk("mid_first_data", 32'(bus.rd_data), 8'h5A);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
